// File: rtl/powlib_pkg.sv
// Shared powlib definitions: reset polarity and a constant clog2 helper.
// All powlib blocks use an asynchronous, active-low reset.
`ifndef POWLIB_RST_ACTIVE
`define POWLIB_RST_ACTIVE 1'b0
`endif

package powlib_pkg;

  localparam logic RST_ACTIVE = `POWLIB_RST_ACTIVE;

  function automatic int clog2(input int val);
    int res;
    res = 32'sd0;
    while ((32'sd1 <<< res) < val) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/powlib_cntr.sv
// Generic powlib counter: steps by X on adv, optional load, synchronous clr to INIT.
// EAR selects an asynchronous (1) or synchronous (0) reset.
module powlib_cntr
  import powlib_pkg::*;
#(
  parameter int W    = 8,
  parameter int X    = 1,
  parameter int INIT = 0,
  parameter int ELD  = 0,
  parameter int EAR  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         ld,
  input  logic [W-1:0] nval,
  input  logic         clr,
  output logic [W-1:0] cntr
);

  localparam logic [W-1:0] INIT_V = W'(INIT);
  localparam logic [W-1:0] STEP_V = W'(X);

  logic [W-1:0] cntr_r;
  logic [W-1:0] cntr_nxt_s;

  // next count: clr beats load, load beats advance
  always_comb begin
    cntr_nxt_s = cntr_r;
    if (clr) begin
      cntr_nxt_s = INIT_V;
    end else if ((ELD != 32'sd0) && ld) begin
      cntr_nxt_s = nval;
    end else if (adv) begin
      cntr_nxt_s = cntr_r + STEP_V;
    end else begin
      cntr_nxt_s = cntr_r;
    end
  end

  generate
    if (EAR != 32'sd0) begin : g_async_rst
      // count register, asynchronous reset
      always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
          cntr_r <= INIT_V;
        end else begin
          cntr_r <= cntr_nxt_s;
        end
      end
    end else begin : g_sync_rst
      // count register, synchronous reset
      always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
          cntr_r <= INIT_V;
        end else begin
          cntr_r <= cntr_nxt_s;
        end
      end
    end
  endgenerate

  assign cntr = cntr_r;

endmodule

// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Define POWLIB_SFIFO_AFULL_EN to enable the registered almost-full flag.
module powlib_sfifo
  import powlib_pkg::*;
#(
  parameter int W   = 8,
  parameter int D   = 8,
  parameter int AFT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [W-1:0]          wrdata,
  input  logic                  wrvld,
  output logic                  wrrdy,
  output logic [W-1:0]          rddata,
  output logic                  rdvld,
  input  logic                  rdrdy,
  output logic [clog2(D):0]     cnt,
  output logic                  afull
);

  localparam int AW = clog2(D);

  generate
    if ((D < 32'sd2) || ((32'sd1 <<< AW) != D)) begin : g_bad_depth
      $error("powlib_sfifo: D must be a power of two and at least 2");
    end
    if ((AFT < 32'sd1) || (AFT > D)) begin : g_bad_aft
      $error("powlib_sfifo: AFT must lie in 1..D");
    end
  endgenerate

  logic [W-1:0] mem_r [D];
  logic [AW:0]  wptr_s;
  logic [AW:0]  rptr_s;
  logic [AW:0]  cnt_s;
  logic         empty_s;
  logic         full_s;
  logic         wr_fire_s;
  logic         rd_fire_s;

  // Flags come from registered pointers only, so ready/valid never see wrvld/rdrdy.
  assign cnt_s     = wptr_s - rptr_s;
  assign empty_s   = (wptr_s == rptr_s);
  assign full_s    = (cnt_s == (AW+1)'(D));
  assign wr_fire_s = wrvld && !full_s;
  assign rd_fire_s = rdrdy && !empty_s;

  powlib_cntr #(
    .W    (AW + 1),
    .X    (1),
    .INIT (0),
    .ELD  (0),
    .EAR  (1)
  ) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .adv  (wr_fire_s),
    .ld   (1'b0),
    .nval ({(AW+1){1'b0}}),
    .clr  (clr),
    .cntr (wptr_s)
  );

  powlib_cntr #(
    .W    (AW + 1),
    .X    (1),
    .INIT (0),
    .ELD  (0),
    .EAR  (1)
  ) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .adv  (rd_fire_s),
    .ld   (1'b0),
    .nval ({(AW+1){1'b0}}),
    .clr  (clr),
    .cntr (rptr_s)
  );

  // storage write; a word offered during clr is dropped
  always_ff @(posedge clk) begin
    if (wr_fire_s && !clr) begin
      mem_r[wptr_s[AW-1:0]] <= wrdata;
    end
  end

  assign rddata = mem_r[rptr_s[AW-1:0]];
  assign rdvld  = !empty_s;
  assign wrrdy  = !full_s;
  assign cnt    = cnt_s;

`ifdef POWLIB_SFIFO_AFULL_EN
  logic [AW+1:0] cnt_nxt_s;
  logic          afull_r;

  // occupancy after this edge's handshakes, one bit wider to hold D+1 safely
  always_comb begin
    cnt_nxt_s = {1'b0, cnt_s} + {{(AW+1){1'b0}}, wr_fire_s} - {{(AW+1){1'b0}}, rd_fire_s};
  end

  // almost-full register, updated on the same edge as the pointers
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      afull_r <= 1'b0;
    end else if (clr) begin
      afull_r <= 1'b0;
    end else begin
      afull_r <= (cnt_nxt_s >= (AW+2)'(AFT));
    end
  end

  assign afull = afull_r;
`else
  assign afull = 1'b0;
`endif

endmodule

// File: tb/tb_powlib_sfifo.sv
// Self-checking bench for powlib_sfifo: queue-based reference model compared every
// cycle, plus directed literal checks for reset, fill/drain, full/empty edges, wrap, clr.
module tb_powlib_sfifo;

  localparam int W   = 8;
  localparam int D   = 8;
  localparam int AFT = 6;
`ifdef POWLIB_SFIFO_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] wrdata = 8'h00;
  logic         wrvld = 1'b0;
  logic         wrrdy;
  logic [W-1:0] rddata;
  logic         rdvld;
  logic         rdrdy = 1'b0;
  logic [3:0]   cnt;
  logic         afull;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  bit           m_afull = 1'b0;
  int           nwr = 0;

  powlib_sfifo #(.W(W), .D(D), .AFT(AFT)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .cnt    (cnt),
    .afull  (afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word queue updated by the handshake rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_afull = 1'b0;
    end else begin
      bit wf, rf;
      wf = wrvld && (q.size() < D);
      rf = rdrdy && (q.size() > 0);
      if (clr) begin
        q.delete();
        m_afull = 1'b0;
      end else begin
        if (rf) void'(q.pop_front());
        if (wf) begin
          q.push_back(wrdata);
          nwr = nwr + 1;
        end
        m_afull = AF_EN && (q.size() >= AFT);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cnt", 32'(cnt), 32'(q.size()));
    chk("rdvld", 32'(rdvld), 32'(q.size() > 0));
    chk("wrrdy", 32'(wrrdy), 32'(q.size() < D));
    chk("afull", 32'(afull), 32'(m_afull));
    if (q.size() > 0) chk("rddata", 32'(rddata), 32'(q[0]));
  end

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr, input logic c);
    wrvld  = wv;
    wrdata = wd;
    rdrdy  = rr;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_wrrdy", 32'(wrrdy), 32'd1);
    rst = 1'b1;

    // test 1: reset mid-run after 3 writes
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0);
    chk("t1_cnt3", 32'(cnt), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_cnt", 32'(cnt), 32'd0);
    chk("t1_rdvld", 32'(rdvld), 32'd0);
    chk("t1_wrrdy", 32'(wrrdy), 32'd1);
    chk("t1_afull", 32'(afull), 32'd0);
    wrvld = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // test 2: fill then drain
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_full_wrrdy", 32'(wrrdy), 32'd0);
    chk("t2_full_cnt", 32'(cnt), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain_data", 32'(rddata), 32'(i));
      chk("t2_drain_vld", 32'(rdvld), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t2_empty_vld", 32'(rdvld), 32'd0);
    chk("t2_empty_cnt", 32'(cnt), 32'd0);

    // test 3: full with simultaneous read and write
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hA0, 1'b1, 1'b0);
    chk("t3_rd_only_cnt", 32'(cnt), 32'd7);
    chk("t3_rd_only_head", 32'(rddata), 32'h12);
    cyc(1'b1, 8'hA1, 1'b1, 1'b0);
    chk("t3_both_cnt", 32'(cnt), 32'd7);
    chk("t3_both_head", 32'(rddata), 32'h13);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_drained", 32'(cnt), 32'd0);

    // test 4: write into empty with rdrdy high: no bypass
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("t4_vld", 32'(rdvld), 32'd1);
    chk("t4_data", 32'(rddata), 32'h5A);
    chk("t4_cnt", 32'(cnt), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_empty", 32'(rdvld), 32'd0);

    // test 5: 40 random words, random valid/ready, pointers wrap
    begin
      int start, budget;
      start  = nwr;
      budget = 0;
      while ((nwr - start) < 40 && budget < 2000) begin
        cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
        budget = budget + 1;
      end
      chk("t5_words_written", 32'(nwr - start >= 40), 32'd1);
      budget = 0;
      while (q.size() > 0 && budget < 50) begin
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        budget = budget + 1;
      end
      chk("t5_drained", 32'(cnt), 32'd0);
    end

    // test 6: almost-full and clr
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("t6_afull_5", 32'(afull), 32'd0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    chk("t6_afull_6", 32'(afull), 32'(AF_EN));
    chk("t6_cnt_6", 32'(cnt), 32'd6);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("t6_clr_cnt", 32'(cnt), 32'd0);
    chk("t6_clr_afull", 32'(afull), 32'd0);
    chk("t6_clr_vld", 32'(rdvld), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_dropped", 32'(rdvld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
